// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead adder: slice width,
// controller state encoding and slice-index sizing.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index register; never narrower than one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla_serial_adder_slice.sv
// Combinational 4-bit generate/propagate carry-lookahead slice.
// c3_o is the carry into bit 3, exported so the caller can form signed overflow.
module cla4_slice (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o,
  output logic       c3_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Lookahead carries computed directly from generate/propagate terms.
  always_comb begin
    g    = x_i & y_i;
    p    = x_i ^ y_i;
    c[0] = ci_i;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_o  = p ^ c[3:0];
    co_o = c[4];
    c3_o = c[3];
  end

endmodule

// File: rtl/cla_serial_adder.sv
// Serial wide adder: one 4-bit CLA slice per clock, LSB slice first.
// Optional macro CLA_SERIAL_OVF_EN adds a registered signed-overflow output.
//
// state | meaning
// IDLE  | waiting for start, ready high
// RUN   | one slice processed per edge, busy high
// DONE  | result just registered, done pulse, ready high (back-to-back accept)
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SERIAL_OVF_EN
  , output logic           overflow
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [SLICE_W-1:0]       sl_s;
  logic                     sl_co;
  logic                     sl_c3;
  logic [WIDTH+SLICE_W-1:0] joined;
  logic [WIDTH-1:0]         part_shift;

  // Operands shift right each RUN edge, so the slice always sees the low nibble.
  cla4_slice u_slice (
    .x_i  (a_q[SLICE_W-1:0]),
    .y_i  (b_q[SLICE_W-1:0]),
    .ci_i (carry_q),
    .s_o  (sl_s),
    .co_o (sl_co),
    .c3_o (sl_c3)
  );

  // New slice result enters at the top of the partial sum; after NSLICE edges
  // slice 0 has arrived at bits [3:0].
  always_comb begin
    joined     = {sl_s, part_q};
    part_shift = joined[WIDTH+SLICE_W-1:SLICE_W];
  end

`ifdef CLA_SERIAL_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_c3;
  assign unused_c3 = sl_c3;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          part_d  = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        part_d  = part_shift;
        carry_d = sl_co;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = part_shift;
          cout_d  = sl_co;
`ifdef CLA_SERIAL_OVF_EN
          ovf_d   = sl_c3 ^ sl_co;
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status flags decode straight from the state register.
  always_comb begin
    ready = (state_q == IDLE) || (state_q == DONE);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    sum   = sum_q;
    cout  = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    overflow = ovf_q;
`endif
  end

endmodule
